// File: rtl/frame_buffer_scanout.sv
// frame_buffer_scanout
//   Raster scan-out engine for the read side of a 4-bpp frame buffer. A
//   start_frame pulse walks every address in raster order on rd_addr. The
//   engine tracks the RAM read latency with a valid shift register and hands
//   the returned pixels to the display driver through a small
//   first-word-fall-through FIFO. The output is a valid/ready stream.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   start_frame         one-cycle request for a full frame scan (ignored while busy)
//   fb_ready            frame buffer accepts reads; issue pauses while low
//   rd_addr[17:0]       registered read address
//   rd_data[3:0]        read data, valid LATENCY cycles after the address
//   pixel_data[3:0]     FIFO head pixel
//   pixel_valid         head pixel valid
//   pixel_ready         consumer accepts (transfer = valid & ready)
//   pixel_sof           head pixel is address 0
//   pixel_eol           head pixel is the last pixel of a line
//   busy                frame in progress
//   frame_done          pulses with the transfer of the final pixel
module frame_buffer_scanout #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 400,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_frame,
  input  logic        fb_ready,
  output logic [17:0] rd_addr,
  input  logic [3:0]  rd_data,
  output logic [3:0]  pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel_sof,
  output logic        pixel_eol,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(LATENCY + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [17:0]         addr_q, addr_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [LATENCY-1:0]  vld_q, vld_d;
  logic [LATENCY-1:0]  sof_p_q, sof_p_d;
  logic [LATENCY-1:0]  eol_p_q, eol_p_d;
  logic [5:0]          mem_q [FIFO_DEPTH];
  logic [5:0]          mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic [FW-1:0] in_flight;
  logic          issue;
  logic          last_pix;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [5:0]    head;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      in_flight = in_flight + FW'(vld_q[i]);
    end
    // Conservative credit: a pop this cycle frees nothing until next cycle.
    issue      = (state_q == READ) && fb_ready &&
                 ((int'(in_flight) + int'(fifo_cnt_q)) < FIFO_DEPTH);
    last_pix   = (x_q == X_LAST) && (y_q == Y_LAST);
    push       = vld_q[LATENCY-1];
    head_valid = (fifo_cnt_q != '0);
    pop        = head_valid && pixel_ready;
    head       = mem_q[rd_ptr_q];

    pixel_valid = head_valid;
    pixel_data  = head_valid ? head[3:0] : '0;
    pixel_eol   = head_valid && head[4];
    pixel_sof   = head_valid && head[5];
    busy        = (state_q != IDLE);
    rd_addr     = addr_q;
    // Nothing left in flight and a single entry leaving: the final pixel.
    frame_done  = (state_q == DRAIN) && (in_flight == '0) &&
                  (fifo_cnt_q == CW'(1)) && pop;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d = READ;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (last_pix) begin
            // Address stays on the final pixel; it never wraps past it.
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + 18'd1;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_d = IDLE;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_d      = '0;
    sof_p_d    = '0;
    eol_p_d    = '0;
    vld_d[0]   = issue;
    sof_p_d[0] = (addr_q == '0);
    eol_p_d[0] = (x_q == X_LAST);
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i]   = vld_q[i-1];
      sof_p_d[i] = sof_p_q[i-1];
      eol_p_d[i] = eol_p_q[i-1];
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {sof_p_q[LATENCY-1], eol_p_q[LATENCY-1], rd_data};
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vld_q      <= '0;
      sof_p_q    <= '0;
      eol_p_q    <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vld_q      <= vld_d;
      sof_p_q    <= sof_p_d;
      eol_p_q    <= eol_p_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule
